alu_imm_control_unit: RTL and testbench
=======================================

Name: alu_imm_control_unit

Overview:
- Hardwired control FSM that sequences the System datapath through instruction fetch and execution of ALU-immediate instructions (addi, andi, ori).
- Replaces hand-driven per-T-state control stimulus.
- Reads IR[31:27] and drives every datapath/memory strobe for steps T0..T5.
- Supports start, stop and halt handling.

Parameters:
- MEM_WAIT, 0, extra cycles T1 is held for 512x32 memory read latency (0..15).
- OPW, 5, opcode field width (IR[31:27]).

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- ir  in  32  IR register contents; only [31:27] used.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetch.
- stop  in  1  level; sampled at the end of T5, returns the FSM to IDLE.
- PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin, Yin, Cout  out  1 each  datapath strobes.
- Gra, Grb, Rin, Rout  out  1 each  register-select strobes.
- Mem_read, Mem_enable512x32  out  1 each  memory strobes.
- alu_op  out  5  ALU opcode.
- run  out  1  high whenever the FSM is outside IDLE.
- instr_done  out  1  one-cycle pulse in T5.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset: clear low asynchronously forces IDLE, clears the wait counter and op_latch, and drives every output to 0. This applies mid-instruction too; no partial strobe may survive.
- Outputs are a Moore decode of the state register plus op_latch. Strobes not listed for a state are 0.
- States and transitions:
  - IDLE: all outputs 0. start=1 moves to T0; otherwise stay.
  - T0: PCout, IncPC, MARin, Zin. Next state is T1; wait counter loads MEM_WAIT.
  - T1: Zlo_out, PCin, MDRin, Mem_read, Mem_enable512x32. While counter is nonzero, decrement and stay; at 0, go to T2. Occupancy is exactly MEM_WAIT+1 cycles.
  - T2: MDRout, IRin. Next state is T3.
  - T3: decode ir[31:27] and latch the op into op_latch.
    - ADDI 5'b00011, ANDI 5'b01011, ORI 5'b01010: assert Grb, Rout, Yin; go to T4.
    - HALT 5'b11011: no strobes; go to IDLE.
    - Any other opcode: pulse illegal_op; go to T0 (instruction skipped).
  - T4: Cout, Zin, alu_op = op_latch. alu_op is 0 in every other state. Next state is T5.
  - T5: Zlo_out, Gra, Rin, instr_done. stop=1 goes to IDLE; otherwise go to T0.
- start is ignored outside IDLE. stop is ignored outside T5.
- Instruction latency with MEM_WAIT=0 is 6 cycles (T0..T5).
- run is 0 only in IDLE.
- op_latch holds its value until the next T3; later IR changes do not affect T4.
- PC increment wraps naturally in the datapath; the FSM has no address awareness.

Optional Feature:
- Macro CTRL_ILLEGAL_HALT_EN.
- Defined: an unsupported opcode at T3 pulses illegal_op and goes to IDLE (run drops) instead of T0. A new start is then required to resume.
- Undefined: illegal opcodes are skipped as described under Behaviour.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (IDLE, T0, T1, T2, T3, T4, T5);
  - opcode constants OP_ADDI, OP_ANDI, OP_ORI, OP_HALT;
  - a packed control-word struct covering all strobe outputs.
- Sub-module ctrl_decode: purely combinational; maps (state, op_latch, ir opcode) to the control word.
- The top level holds the state register, wait counter, op_latch and transition logic.

Test Plan:
1. Memory word 0 = 0x18900001 (addi r1,r2,1), r2=0x14, MEM_WAIT=0, pulse start -> r1=0x15 after 6 cycles; instr_done pulses in the 6th cycle; PC=1.
2. Words 0..2 = 0x18900001, 0x58900003, 0x50900009, r2=0x14 -> r1 equals 0x15, then 0x00000000 (0x14&3), then 0x1D; alu_op is 00011, 01011, 01010 in the respective T4 cycles.
3. MEM_WAIT=3 with test 1 -> T1 lasts exactly 4 cycles; Mem_read is high for 4 cycles; total latency 9; r1=0x15.
4. Word 0 = 0xD8000000 (halt) -> run drops after T3, all outputs 0. A start pulse then refetches from PC=1.
5. Word 0 = 0xF8000000 (illegal) -> illegal_op pulses once in T3 and the next cycle is T0 (macro undefined); with CTRL_ILLEGAL_HALT_EN, the FSM goes to IDLE.
6. clear low during T4 of test 1 -> all outputs 0 immediately with no Rin pulse, r1 unchanged, and the FSM stays in IDLE until start. Also: stop held high -> IDLE after the first T5.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the ALU-immediate control unit: FSM states, opcodes
// and the packed control word that carries every strobe.
package ctrl_pkg;

  localparam int OP_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6
  } state_t;

  localparam logic [OP_W-1:0] OP_ADDI = 5'b00011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic            pc_out;
    logic            inc_pc;
    logic            mar_in;
    logic            z_in;
    logic            zlo_out;
    logic            pc_in;
    logic            mdr_in;
    logic            mdr_out;
    logic            ir_in;
    logic            y_in;
    logic            c_out;
    logic            gra;
    logic            grb;
    logic            r_in;
    logic            r_out;
    logic            mem_read;
    logic            mem_enable;
    logic [OP_W-1:0] alu_op;
    logic            run;
    logic            instr_done;
    logic            illegal_op;
  } ctrl_word_t;

  function automatic logic is_alu_imm(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational Moore decode: state plus latched/live opcode to control word.
// The live IR opcode only matters in T3, where the instruction is classified.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  state_t         state,
  input  logic [OPW-1:0] op_latch,
  input  logic [OPW-1:0] ir_op,
  output ctrl_word_t     cw
);

  always_comb begin
    cw = '0;
    case (state)
      IDLE: cw = '0;
      T0: begin
        cw.run    = 1'b1;
        cw.pc_out = 1'b1;
        cw.inc_pc = 1'b1;
        cw.mar_in = 1'b1;
        cw.z_in   = 1'b1;
      end
      T1: begin
        cw.run        = 1'b1;
        cw.zlo_out    = 1'b1;
        cw.pc_in      = 1'b1;
        cw.mdr_in     = 1'b1;
        cw.mem_read   = 1'b1;
        cw.mem_enable = 1'b1;
      end
      T2: begin
        cw.run     = 1'b1;
        cw.mdr_out = 1'b1;
        cw.ir_in   = 1'b1;
      end
      T3: begin
        cw.run = 1'b1;
        // HALT is legal but drives nothing; everything else unknown flags illegal
        if (is_alu_imm(ir_op)) begin
          cw.grb   = 1'b1;
          cw.r_out = 1'b1;
          cw.y_in  = 1'b1;
        end else if (ir_op != OP_HALT) begin
          cw.illegal_op = 1'b1;
        end
      end
      T4: begin
        cw.run    = 1'b1;
        cw.c_out  = 1'b1;
        cw.z_in   = 1'b1;
        cw.alu_op = OP_W'(op_latch);
      end
      T5: begin
        cw.run        = 1'b1;
        cw.zlo_out    = 1'b1;
        cw.gra        = 1'b1;
        cw.r_in       = 1'b1;
        cw.instr_done = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/alu_imm_control_unit.sv
// Hardwired fetch/execute sequencer for addi/andi/ori. Define
// CTRL_ILLEGAL_HALT_EN to stop in IDLE on an illegal opcode instead of skipping it.
module alu_imm_control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int OPW      = 5
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        start,
  input  logic        stop,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        Zin,
  output logic        Zlo_out,
  output logic        PCin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        Mem_read,
  output logic        Mem_enable512x32,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        instr_done,
  output logic        illegal_op
);

  localparam logic [3:0] WAIT_INIT = MEM_WAIT[3:0];

  state_t         state_reg, state_next;
  logic [3:0]     wait_cnt_reg, wait_cnt_next;
  logic [OPW-1:0] op_latch_reg, op_latch_next;
  logic [OPW-1:0] ir_op;
  ctrl_word_t     cw;
  logic           unused_ir;

  assign ir_op     = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      op_latch_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      op_latch_reg <= op_latch_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    op_latch_next = op_latch_reg;
    case (state_reg)
      IDLE: if (start) state_next = T0;
      T0: begin
        state_next    = T1;
        wait_cnt_next = WAIT_INIT;
      end
      // Hold the read strobes until the memory has had MEM_WAIT extra cycles
      T1: begin
        if (wait_cnt_reg != 4'd0) wait_cnt_next = wait_cnt_reg - 4'd1;
        else                      state_next    = T2;
      end
      T2: state_next = T3;
      T3: begin
        op_latch_next = ir_op;
        if (is_alu_imm(ir_op))     state_next = T4;
        else if (ir_op == OP_HALT) state_next = IDLE;
        else begin
`ifdef CTRL_ILLEGAL_HALT_EN
          state_next = IDLE;
`else
          state_next = T0;
`endif
        end
      end
      T4: state_next = T5;
      T5: state_next = stop ? IDLE : T0;
      default: state_next = IDLE;
    endcase
  end

  ctrl_decode #(.OPW(OPW)) u_decode (
    .state    (state_reg),
    .op_latch (op_latch_reg),
    .ir_op    (ir_op),
    .cw       (cw)
  );

  assign PCout            = cw.pc_out;
  assign IncPC            = cw.inc_pc;
  assign MARin            = cw.mar_in;
  assign Zin              = cw.z_in;
  assign Zlo_out          = cw.zlo_out;
  assign PCin             = cw.pc_in;
  assign MDRin            = cw.mdr_in;
  assign MDRout           = cw.mdr_out;
  assign IRin             = cw.ir_in;
  assign Yin              = cw.y_in;
  assign Cout             = cw.c_out;
  assign Gra              = cw.gra;
  assign Grb              = cw.grb;
  assign Rin              = cw.r_in;
  assign Rout             = cw.r_out;
  assign Mem_read         = cw.mem_read;
  assign Mem_enable512x32 = cw.mem_enable;
  assign alu_op           = cw.alu_op;
  assign run              = cw.run;
  assign instr_done       = cw.instr_done;
  assign illegal_op       = cw.illegal_op;

endmodule

// File: tb/tb_alu_imm_control_unit.sv
// Randomized bench: two instances (MEM_WAIT 0 and 3) checked cycle by cycle
// against an instruction-level model of the fetch/execute step sequence.
module tb_alu_imm_control_unit;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic             clear;
  logic [1:0]       start_s;
  logic [1:0]       stop_s;
  logic [1:0][31:0] ir_s;
  logic [1:0][24:0] obs_s;

  // Bit positions of the observed output vector
  localparam int B_ILL = 0, B_DONE = 1, B_RUN = 2, B_ALU = 3, B_MEN = 8, B_MRD = 9;
  localparam int B_ROUT = 10, B_RIN = 11, B_GRB = 12, B_GRA = 13, B_COUT = 14, B_YIN = 15;
  localparam int B_IRIN = 16, B_MDROUT = 17, B_MDRIN = 18, B_PCIN = 19, B_ZLO = 20;
  localparam int B_ZIN = 21, B_MARIN = 22, B_INC = 23, B_PCOUT = 24;

  localparam logic [24:0] ONE    = 25'd1;
  localparam logic [24:0] W_IDLE = 25'd0;
  localparam logic [24:0] W_T0 = (ONE << B_PCOUT) | (ONE << B_INC) | (ONE << B_MARIN) |
                                 (ONE << B_ZIN) | (ONE << B_RUN);
  localparam logic [24:0] W_T1 = (ONE << B_ZLO) | (ONE << B_PCIN) | (ONE << B_MDRIN) |
                                 (ONE << B_MRD) | (ONE << B_MEN) | (ONE << B_RUN);
  localparam logic [24:0] W_T2 = (ONE << B_MDROUT) | (ONE << B_IRIN) | (ONE << B_RUN);
  localparam logic [24:0] W_T3_ALU = (ONE << B_GRB) | (ONE << B_ROUT) | (ONE << B_YIN) |
                                     (ONE << B_RUN);
  localparam logic [24:0] W_T3_HALT = (ONE << B_RUN);
  localparam logic [24:0] W_T3_ILL  = (ONE << B_RUN) | (ONE << B_ILL);
  localparam logic [24:0] W_T4 = (ONE << B_COUT) | (ONE << B_ZIN) | (ONE << B_RUN);
  localparam logic [24:0] W_T5 = (ONE << B_ZLO) | (ONE << B_GRA) | (ONE << B_RIN) |
                                 (ONE << B_DONE) | (ONE << B_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin, Yin, Cout;
      logic Gra, Grb, Rin, Rout, Mem_read, Mem_enable512x32, run, instr_done, illegal_op;
      logic [4:0] alu_op;

      alu_imm_control_unit #(.MEM_WAIT(gi * 3), .OPW(5)) u_dut (
        .Clock            (Clock),
        .clear            (clear),
        .ir               (ir_s[gi]),
        .start            (start_s[gi]),
        .stop             (stop_s[gi]),
        .PCout            (PCout),
        .IncPC            (IncPC),
        .MARin            (MARin),
        .Zin              (Zin),
        .Zlo_out          (Zlo_out),
        .PCin             (PCin),
        .MDRin            (MDRin),
        .MDRout           (MDRout),
        .IRin             (IRin),
        .Yin              (Yin),
        .Cout             (Cout),
        .Gra              (Gra),
        .Grb              (Grb),
        .Rin              (Rin),
        .Rout             (Rout),
        .Mem_read         (Mem_read),
        .Mem_enable512x32 (Mem_enable512x32),
        .alu_op           (alu_op),
        .run              (run),
        .instr_done       (instr_done),
        .illegal_op       (illegal_op)
      );

      assign obs_s[gi] = {PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin,
                          Yin, Cout, Gra, Grb, Rin, Rout, Mem_read, Mem_enable512x32,
                          alu_op, run, instr_done, illegal_op};
    end
  endgenerate

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Sample the current cycle's outputs, then advance to the next falling edge
  task automatic expect_cycle(input int sel, input string tag, input logic [24:0] exp);
    #1;
    check($sformatf("%s dut%0d", tag, sel), {7'd0, obs_s[sel]}, {7'd0, exp});
    @(negedge Clock);
  endtask

  // start/stop values that the FSM must ignore in the current state
  task automatic noise(input int sel);
    start_s[sel] = 1'($urandom);
    stop_s[sel]  = 1'($urandom);
  endtask

  task automatic do_start(input int sel);
    int idle_n;
    idle_n = $urandom_range(0, 2);
    for (int i = 0; i < idle_n; i++) begin
      start_s[sel] = 1'b0;
      stop_s[sel]  = 1'($urandom);
      expect_cycle(sel, "idle_hold", W_IDLE);
    end
    start_s[sel] = 1'b1;
    expect_cycle(sel, "idle_start", W_IDLE);
    start_s[sel] = 1'b0;
  endtask

  function automatic bit is_alu(input logic [4:0] op);
    return op == 5'b00011 || op == 5'b01011 || op == 5'b01010;
  endfunction

  // Walks one instruction from T0 to its end; reports whether the FSM is now idle
  task automatic run_instr(input int sel, input logic [31:0] instr, input bit stop_v,
                           input bit abort, output bit idle_after);
    logic [4:0] op;
    op = instr[31:27];
    idle_after = 1'b0;
    noise(sel); ir_s[sel] = $urandom;
    expect_cycle(sel, "T0", W_T0);
    for (int i = 0; i <= sel * 3; i++) begin
      noise(sel);
      expect_cycle(sel, "T1", W_T1);
    end
    noise(sel);
    expect_cycle(sel, "T2", W_T2);
    noise(sel); ir_s[sel] = instr;
    if (is_alu(op)) begin
      expect_cycle(sel, "T3_alu", W_T3_ALU);
      noise(sel); ir_s[sel] = $urandom;
      if (abort) begin
        #1;
        check("T4_pre_abort", {7'd0, obs_s[sel]}, {7'd0, W_T4 | (25'(op) << B_ALU)});
        start_s[sel] = 1'b0;
        clear = 1'b0;
        #1;
        check("clear_async", {7'd0, obs_s[sel]}, 32'd0);
        @(posedge Clock); #1;
        check("clear_no_rin", {7'd0, obs_s[sel]}, 32'd0);
        @(negedge Clock);
        clear = 1'b1;
        expect_cycle(sel, "post_clear_idle", W_IDLE);
        idle_after = 1'b1;
      end else begin
        expect_cycle(sel, "T4", W_T4 | (25'(op) << B_ALU));
        start_s[sel] = 1'($urandom);
        stop_s[sel]  = stop_v;
        expect_cycle(sel, "T5", W_T5);
        idle_after = stop_v;
      end
    end else if (op == 5'b11011) begin
      expect_cycle(sel, "T3_halt", W_T3_HALT);
      idle_after = 1'b1;
    end else begin
      expect_cycle(sel, "T3_illegal", W_T3_ILL);
`ifdef CTRL_ILLEGAL_HALT_EN
      idle_after = 1'b1;
`else
      idle_after = 1'b0;
`endif
    end
    start_s[sel] = 1'b0;
    stop_s[sel]  = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      case ($urandom_range(0, 2))
        0:       op = 5'b00011;
        1:       op = 5'b01011;
        default: op = 5'b01010;
      endcase
    end else if (r < 8) begin
      op = 5'b11011;
    end else begin
      op = 5'($urandom);
      if (is_alu(op) || op == 5'b11011) op = 5'b11111;
    end
    return {op, 27'($urandom)};
  endfunction

  task automatic run_phase(input int sel);
    logic [31:0] directed [6];
    bit idle;
    directed = '{32'h18900001, 32'h58900003, 32'h50900009, 32'hD8000000,
                 32'hF8000000, 32'h18900001};
    do_start(sel);
    for (int i = 0; i < 36; i++) begin
      logic [31:0] instr;
      bit stop_v, abort;
      instr  = (i < 6) ? directed[i] : rand_instr();
      stop_v = (i < 5) ? 1'b0 : ($urandom_range(0, 3) == 0);
      abort  = (i == 5) && (sel == 0);
      run_instr(sel, instr, stop_v, abort, idle);
      if (idle) do_start(sel);
    end
    // Leave the instance parked in IDLE: keep stop high until a T5 arrives
    for (int i = 0; i < 40 && !idle; i++) begin
      run_instr(sel, 32'h18900001, 1'b1, 1'b0, idle);
    end
  endtask

  initial begin
    clear   = 1'b0;
    start_s = '0;
    stop_s  = '0;
    ir_s    = '0;
    repeat (2) @(negedge Clock);
    #1;
    check("reset dut0", {7'd0, obs_s[0]}, 32'd0);
    check("reset dut1", {7'd0, obs_s[1]}, 32'd0);
    @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    run_phase(0);
    run_phase(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
